// File: rtl/n64_pad_ctrl.sv
// N64 controller poll/decode stage: periodic poll requests, a timeout watchdog with receiver
// recovery, button/stick decode, and a 4-deep show-ahead event FIFO for changed pad states.
module n64_pad_ctrl #(
    parameter int unsigned CLK_FREQ       = 30_000_000,
    parameter int unsigned POLL_PERIOD_US = 1000,
    parameter int unsigned TIMEOUT_US     = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rx_go,
    output logic        rx_rst,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic [15:0] buttons,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        pad_present,
    output logic [7:0]  timeout_cnt,
    output logic [31:0] evt_data,
    output logic        evt_empty,
    input  logic        evt_rd,
    output logic        evt_ovf
);

    localparam int unsigned TPU        = CLK_FREQ / 1_000_000;
    localparam int unsigned POLL_TICKS = POLL_PERIOD_US * TPU;
    localparam int unsigned TO_TICKS   = TIMEOUT_US * TPU;
    localparam int unsigned PW         = $clog2(POLL_TICKS + 1);
    localparam int unsigned TW         = $clog2(TO_TICKS + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_TICKS - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TO_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_BUSY,
        S_RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   per_cnt_q, per_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            rec_cnt_q, rec_cnt_d;
    logic [15:0]     buttons_q;
    logic [7:0]      stick_x_q, stick_y_q;
    logic            pad_present_q, pad_present_d;
    logic [7:0]      timeout_cnt_q, timeout_cnt_d;
    logic            accept;

    logic [31:0]     fifo_mem_q [4];
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      count_q, count_d;
    logic            ovf_q;
    logic            push, pop, full, wr_en;
    logic [31:0]     new_word, last_word;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Both counters read zero during the rx_go cycle, so they measure cycles since rx_go.
    always_comb begin
        state_d       = state_q;
        per_cnt_d     = (per_cnt_q == POLL_MAX) ? per_cnt_q : per_cnt_q + PW'(1);
        to_cnt_d      = to_cnt_q;
        rec_cnt_d     = 1'b0;
        pad_present_d = pad_present_q;
        timeout_cnt_d = timeout_cnt_q;
        accept        = 1'b0;
        case (state_q)
            S_IDLE: begin
                per_cnt_d = POLL_MAX;
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) state_d = S_IDLE;
                else if (per_cnt_q >= POLL_MAX) state_d = S_REQ;
            end
            S_REQ: begin
                to_cnt_d = to_cnt_q + TW'(1);
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                if (rx_valid) begin
                    accept        = 1'b1;
                    pad_present_d = 1'b1;
                    state_d       = enable ? S_WAIT : S_IDLE;
                end else if (to_cnt_q == TO_MAX) begin
                    state_d = S_RECOVER;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_RECOVER: begin
                rec_cnt_d = ~rec_cnt_q;
                if (!rec_cnt_q) begin
                    pad_present_d = 1'b0;
                    if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
                end else begin
                    state_d = enable ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_REQ) begin
            per_cnt_d = '0;
            to_cnt_d  = '0;
        end
    end

    always_comb begin
        new_word  = {bitrev8(rx_data[31:24]), bitrev8(rx_data[23:16]), rx_data[15:0]};
        last_word = {stick_y_q, stick_x_q, buttons_q};
        push      = accept && ((new_word != last_word) || !pad_present_q);
        pop       = evt_rd && (count_q != 3'd0);
        full      = (count_q == 3'd4);
        wr_en     = push && (!full || pop);
        count_d   = count_q + {2'b00, wr_en} - {2'b00, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            per_cnt_q     <= POLL_MAX;
            to_cnt_q      <= '0;
            rec_cnt_q     <= 1'b0;
            buttons_q     <= '0;
            stick_x_q     <= '0;
            stick_y_q     <= '0;
            pad_present_q <= 1'b0;
            timeout_cnt_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            to_cnt_q      <= to_cnt_d;
            rec_cnt_q     <= rec_cnt_d;
            pad_present_q <= pad_present_d;
            timeout_cnt_q <= timeout_cnt_d;
            if (accept) begin
                buttons_q <= new_word[15:0];
                stick_x_q <= new_word[23:16];
                stick_y_q <= new_word[31:24];
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem_q[wr_ptr_q] <= new_word;
    end

    assign rx_go       = (state_q == S_REQ);
    assign rx_rst      = reset || (state_q == S_RECOVER);
    assign buttons     = buttons_q;
    assign stick_x     = stick_x_q;
    assign stick_y     = stick_y_q;
    assign pad_present = pad_present_q;
    assign timeout_cnt = timeout_cnt_q;
    assign evt_empty   = (count_q == 3'd0);
    assign evt_data    = evt_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign evt_ovf     = ovf_q;

endmodule

// File: tb/tb_n64_pad_ctrl.sv
// Directed bench for n64_pad_ctrl: the bench plays the receiver, answering each rx_go
// after a chosen delay, and checks decode, timing, timeout recovery and FIFO behaviour.
module tb_n64_pad_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, rx_go, rx_rst, rx_valid, pad_present;
    logic        evt_empty, evt_rd, evt_ovf;
    logic [31:0] rx_data, evt_data;
    logic [15:0] buttons;
    logic [7:0]  stick_x, stick_y, timeout_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned go_count = 0;
    int unsigned rst_cycles = 0;
    int unsigned rst_rise = 0;
    logic        rst_prev = 1'b0;

    n64_pad_ctrl #(
        .CLK_FREQ(10_000_000),
        .POLL_PERIOD_US(20),
        .TIMEOUT_US(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rx_go(rx_go),
        .rx_rst(rx_rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .buttons(buttons),
        .stick_x(stick_x),
        .stick_y(stick_y),
        .pad_present(pad_present),
        .timeout_cnt(timeout_cnt),
        .evt_data(evt_data),
        .evt_empty(evt_empty),
        .evt_rd(evt_rd),
        .evt_ovf(evt_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_go) go_count <= go_count + 1;
        if (rx_rst && !reset) begin
            rst_cycles <= rst_cycles + 1;
            if (!rst_prev) rst_rise <= cyc;
        end
        rst_prev <= rx_rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_go(input int limit, output int unsigned t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (rx_go) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic do_poll(input logic [31:0] w, input bit answer, input int dly,
                           input bit pop, output int unsigned t);
        bit ok;
        wait_go(400, t, ok);
        check("poll_go", {31'b0, ok}, 32'd1);
        if (answer && ok) begin
            repeat (dly) @(negedge clk);
            rx_data  = w;
            rx_valid = 1'b1;
            evt_rd   = pop;
            @(negedge clk);
            rx_valid = 1'b0;
            evt_rd   = 1'b0;
            rx_data  = '0;
        end
    endtask

    task automatic pop_check(input logic [31:0] exp);
        check("evt_head", evt_data, exp);
        check("evt_nonempty", {31'b0, evt_empty}, 32'd0);
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
    endtask

    initial begin
        int unsigned t1, t2, ta, tb, t4, t_en, rc, gc;
        bit ok;
        reset    = 1'b1;
        enable   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        evt_rd   = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rx_rst", {31'b0, rx_rst}, 32'd1);
        check("rst_rx_go", {31'b0, rx_go}, 32'd0);
        check("rst_empty", {31'b0, evt_empty}, 32'd1);
        check("rst_present", {31'b0, pad_present}, 32'd0);
        check("rst_outs", {buttons, stick_x, stick_y}, 32'd0);
        check("rst_tocnt", {24'b0, timeout_cnt}, 32'd0);
        check("rst_ovf", {31'b0, evt_ovf}, 32'd0);
        check("rst_evt_data", evt_data, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_rx_rst", {31'b0, rx_rst}, 32'd0);
        check("idle_no_go", go_count, 32'd0);

        // First poll is immediate; push with a pop on an empty FIFO still lands
        enable = 1'b1;
        t_en   = cyc;
        do_poll(32'h0000_0001, 1'b1, 50, 1'b1, t1);
        check("first_go_lat", t1 - t_en, 32'd2);
        check("go_one_cycle", go_count, 32'd1);
        check("t1_buttons", {16'b0, buttons}, 32'h0000_0001);
        check("t1_present", {31'b0, pad_present}, 32'd1);
        pop_check(32'h0000_0001);
        check("t1_empty", {31'b0, evt_empty}, 32'd1);

        do_poll(32'h0E01_0000, 1'b1, 50, 1'b0, t2);
        check("poll_spacing", t2 - t1, 32'd200);
        check("t2_stick_x", {24'b0, stick_x}, 32'h80);
        check("t2_stick_y", {24'b0, stick_y}, 32'h70);
        check("t2_buttons", {16'b0, buttons}, 32'd0);
        pop_check(32'h7080_0000);

        do_poll(32'h0000_5A5A, 1'b1, 50, 1'b0, ta);
        do_poll(32'h0000_5A5A, 1'b1, 50, 1'b0, tb);
        do_poll(32'h0000_5A5A, 1'b1, 50, 1'b0, tb);
        check("t3_spacing", tb - ta, 32'd400);
        pop_check(32'h0000_5A5A);
        check("t3_one_event", {31'b0, evt_empty}, 32'd1);

        rc = rst_cycles;
        do_poll(32'h0, 1'b0, 0, 1'b0, t4);
        repeat (110) @(negedge clk);
        check("to_rst_delay", rst_rise - t4, 32'd100);
        check("to_rst_len", rst_cycles - rc, 32'd2);
        check("to_present", {31'b0, pad_present}, 32'd0);
        check("to_count", {24'b0, timeout_cnt}, 32'd1);
        check("to_no_event", {31'b0, evt_empty}, 32'd1);
        do_poll(32'h0000_5A5A, 1'b1, 50, 1'b0, t4);
        check("rec_present", {31'b0, pad_present}, 32'd1);
        pop_check(32'h0000_5A5A);

        for (int i = 1; i <= 5; i++) begin
            do_poll(32'h11 * i, 1'b1, 20, 1'b0, ta);
        end
        check("ovf_set", {31'b0, evt_ovf}, 32'd1);
        check("ovf_head", evt_data, 32'h0000_0011);
        check("ovf_latched", {16'b0, buttons}, 32'h0000_0055);
        do_poll(32'h0000_0066, 1'b1, 20, 1'b1, ta);
        pop_check(32'h0000_0022);
        pop_check(32'h0000_0033);
        pop_check(32'h0000_0044);
        pop_check(32'h0000_0066);
        check("fifo_drained", {31'b0, evt_empty}, 32'd1);
        check("ovf_sticky", {31'b0, evt_ovf}, 32'd1);

        // Disable mid-transaction: the late answer is still taken, then polling stops
        wait_go(400, ta, ok);
        check("t6_go", {31'b0, ok}, 32'd1);
        @(negedge clk);
        enable = 1'b0;
        repeat (29) @(negedge clk);
        rx_data  = 32'h0000_0077;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("late_buttons", {16'b0, buttons}, 32'h0000_0077);
        check("late_event", evt_data, 32'h0000_0077);
        gc = go_count;
        repeat (300) @(negedge clk);
        check("disabled_no_go", go_count - gc, 32'd0);

        enable = 1'b1;
        wait_go(10, ta, ok);
        check("reen_go", {31'b0, ok}, 32'd1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_empty", {31'b0, evt_empty}, 32'd1);
        check("mid_rst_rx_rst", {31'b0, rx_rst}, 32'd1);
        check("mid_rst_outs", {buttons, stick_x, stick_y}, 32'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_hold", {31'b0, rx_rst}, 32'd1);
        reset = 1'b0;
        gc = go_count;
        repeat (300) @(negedge clk);
        check("post_rst_idle", go_count - gc, 32'd0);
        check("post_rst_rx_rst", {31'b0, rx_rst}, 32'd0);
        enable = 1'b1;
        wait_go(5, ta, ok);
        check("post_rst_go", {31'b0, ok}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
